// File: rtl/ucaspian_axon_dq.sv
// ucaspian_axon_dq: delayed axon fire queue that turns neuron fires into synapse address ranges
// Ports: clk/reset (sync, active-low); enable advances the FSM; clear_act/clear_config wipe the
// delay/config RAMs (clear_done when finished); cfg_* writes {delay, syn_start, syn_cnt} entries;
// axon_addr/axon_vld/axon_rdy accept fires; next_step/step_done bracket a timestep scan;
// syn_start/syn_end/syn_vld/syn_rdy emit inclusive synapse ranges.
module ucaspian_axon_dq #(
  parameter int NEURONS = 256,
  parameter int SYN_W = 12,
  parameter int CNT_W = 8,
  parameter int DELAY_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear_act,
  input  logic clear_config,
  output logic clear_done,
  input  logic [$clog2(NEURONS)-1:0] cfg_addr,
  input  logic [DELAY_W+SYN_W+CNT_W-1:0] cfg_data,
  input  logic cfg_we,
  input  logic next_step,
  output logic step_done,
  input  logic [$clog2(NEURONS)-1:0] axon_addr,
  input  logic axon_vld,
  output logic axon_rdy,
  output logic [SYN_W-1:0] syn_start,
  output logic [SYN_W-1:0] syn_end,
  output logic syn_vld,
  input  logic syn_rdy
);
  localparam int AW = $clog2(NEURONS);
  localparam int CW = DELAY_W + SYN_W + CNT_W;
  localparam int D = 1 << DELAY_W;
  localparam logic [AW-1:0] LAST = AW'(NEURONS - 1);
  typedef enum logic [2:0] {IDLE, READ, EMIT, SCAN, SCAN_EMIT, CLEAR} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cfg_mem [NEURONS];
  logic [D-1:0] dly_mem [NEURONS];
  logic [AW-1:0] idx_q, idx_d;
  logic [DELAY_W-1:0] ptr_q, ptr_d;
  logic [SYN_W-1:0] start_q, start_d, end_q, end_d;
  logic pend_q, pend_d, rdy_en_q, vld_q, vld_d, done_q, done_d, cdone_q, cdone_d;
  logic [CW-1:0] ent;
  logic [DELAY_W-1:0] e_dly;
  logic [SYN_W-1:0] e_start, e_end;
  logic [CNT_W-1:0] e_cnt;
  logic [D-1:0] dly_rd, dly_wd;
  logic dly_we, cfg_clr, clr_req, go_step, emit_done, last;
  // idx_q is shared: captured fire address, scan index, or clear index
  assign ent = cfg_mem[idx_q];
  assign dly_rd = dly_mem[idx_q];
  assign e_dly = ent[CW-1 -: DELAY_W];
  assign e_start = ent[SYN_W+CNT_W-1 -: SYN_W];
  assign e_cnt = ent[CNT_W-1:0];
  assign e_end = e_start + SYN_W'(e_cnt) - SYN_W'(1);
  assign clr_req = clear_act | clear_config;
  assign go_step = state_q == IDLE && enable && (pend_q || next_step);
  assign emit_done = !vld_q || syn_rdy;
  assign last = idx_q == LAST;
  // a step request in IDLE is served ahead of any fire, so the fire port is held off that cycle
  assign axon_rdy = state_q == IDLE && rdy_en_q && enable && !clr_req && !pend_q && !next_step;
  assign syn_start = start_q;
  assign syn_end = end_q;
  assign syn_vld = vld_q;
  assign step_done = done_q;
  assign clear_done = cdone_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    start_d = start_q;
    end_d = end_q;
    vld_d = vld_q;
    done_d = 1'b0;
    cdone_d = cdone_q;
    dly_we = 1'b0;
    dly_wd = dly_rd;
    cfg_clr = 1'b0;
    pend_d = go_step ? 1'b0 : (pend_q | next_step);
    if (clr_req && state_q != CLEAR) begin
      state_d = CLEAR;
      idx_d = '0;
      vld_d = 1'b0;
      cdone_d = 1'b0;
      pend_d = 1'b0;
    end else if (state_q == CLEAR) begin
      ptr_d = '0;
      pend_d = 1'b0;
      if (!clr_req) begin
        state_d = IDLE;
        cdone_d = 1'b0;
      end else if (!cdone_q) begin
        dly_we = clear_act;
        dly_wd = '0;
        cfg_clr = clear_config;
        idx_d = idx_q + AW'(1);
        cdone_d = last;
      end
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (go_step) begin
            ptr_d = ptr_q + DELAY_W'(1);
            idx_d = '0;
            state_d = SCAN;
          end else if (axon_vld && axon_rdy) begin
            idx_d = axon_addr;
            state_d = READ;
          end
        end
        READ: begin
          if (e_dly == '0) begin
            start_d = e_start;
            end_d = e_end;
            vld_d = e_cnt != '0;
            state_d = EMIT;
          end else begin
            // target slot wraps naturally in DELAY_W bits; OR coalesces repeat fires
            dly_we = 1'b1;
            dly_wd = dly_rd | (D'(1) << (ptr_q + e_dly));
            state_d = IDLE;
          end
        end
        EMIT: begin
          if (emit_done) begin
            vld_d = 1'b0;
            state_d = IDLE;
          end
        end
        SCAN: begin
          if (dly_rd[ptr_q]) begin
            dly_we = 1'b1;
            dly_wd = dly_rd & ~(D'(1) << ptr_q);
            start_d = e_start;
            end_d = e_end;
            vld_d = e_cnt != '0;
            state_d = SCAN_EMIT;
          end else if (last) begin
            done_d = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
        SCAN_EMIT: begin
          if (emit_done) begin
            vld_d = 1'b0;
            done_d = last;
            idx_d = last ? idx_q : idx_q + AW'(1);
            state_d = last ? IDLE : SCAN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      ptr_q <= '0;
      pend_q <= 1'b0;
      rdy_en_q <= 1'b0;
      start_q <= '0;
      end_q <= '0;
      vld_q <= 1'b0;
      done_q <= 1'b0;
      cdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      pend_q <= pend_d;
      rdy_en_q <= 1'b1;
      start_q <= start_d;
      end_q <= end_d;
      vld_q <= vld_d;
      done_q <= done_d;
      cdone_q <= cdone_d;
    end
  end
  // RAM contents survive reset; only the clear requests wipe them
  always_ff @(posedge clk) begin
    if (reset && dly_we) dly_mem[idx_q] <= dly_wd;
    if (reset && cfg_clr) cfg_mem[idx_q] <= '0;
    else if (reset && cfg_we && !clear_config) cfg_mem[cfg_addr] <= cfg_data;
  end
endmodule

// File: tb/tb_ucaspian_axon_dq.sv
// tb_ucaspian_axon_dq: randomized self-checking bench with an in-bench emission model
`timescale 1ns/1ps
module tb_ucaspian_axon_dq;
  localparam int N = 32, SW = 12, CNW = 8, DW = 4, D = 16, AW = 5, CW = 24;
  logic clk = 0, reset = 0, enable = 1, clear_act = 0, clear_config = 0, cfg_we = 0;
  logic next_step = 0, axon_vld = 0, syn_rdy = 0;
  logic [AW-1:0] cfg_addr = '0, axon_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic clear_done, step_done, axon_rdy, syn_vld;
  logic [SW-1:0] syn_start, syn_end;
  always #5 clk = ~clk;
  ucaspian_axon_dq #(.NEURONS(N), .SYN_W(SW), .CNT_W(CNW), .DELAY_W(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_act(clear_act), .clear_config(clear_config),
    .clear_done(clear_done), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_we(cfg_we),
    .next_step(next_step), .step_done(step_done), .axon_addr(axon_addr), .axon_vld(axon_vld),
    .axon_rdy(axon_rdy), .syn_start(syn_start), .syn_end(syn_end), .syn_vld(syn_vld), .syn_rdy(syn_rdy)
  );
  int compared = 0, mismatched = 0;
  int m_dly [N], m_start [N], m_cnt [N];
  bit due [N][D];
  int s_m = 0;
  int exp_q [$];
  int exp_steps = 0, got_steps = 0, hs_cnt = 0, last_start = 0, last_end = 0;
  int rdy_mode = 0;
  int h0, g0;
  function automatic void check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction
  function automatic void emis(int n);
    if (m_cnt[n] != 0) exp_q.push_back((m_start[n] << 12) | ((m_start[n] + m_cnt[n] - 1) & 'hFFF));
  endfunction
  function automatic void model_fire(int n);
    if (m_dly[n] == 0) emis(n);
    else due[n][(s_m + m_dly[n]) % D] = 1'b1;
  endfunction
  function automatic void model_step();
    s_m = (s_m + 1) % D;
    for (int n = 0; n < N; n++) if (due[n][s_m]) begin
      due[n][s_m] = 1'b0;
      emis(n);
    end
    exp_steps++;
  endfunction
  initial forever begin
    @(posedge clk); #1;
    syn_rdy = (rdy_mode == 2) || (rdy_mode == 0 && $urandom_range(0, 2) != 0);
  end
  logic pv = 0, pr = 0, psd = 0;
  logic [SW-1:0] ps = '0, pe = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (syn_vld) begin
        check("syn_vld_expected", int'(exp_q.size() != 0), 1);
        if (pv && !pr) begin
          check("hold_start", syn_start, ps);
          check("hold_end", syn_end, pe);
        end
        if (syn_rdy && exp_q.size() != 0) begin
          check("emit_start", syn_start, exp_q[0] >> 12);
          check("emit_end", syn_end, exp_q[0] & 'hFFF);
          void'(exp_q.pop_front());
          hs_cnt++;
          last_start = syn_start;
          last_end = syn_end;
        end
      end
      if (step_done) begin
        check("step_done_width", psd, 0);
        got_steps++;
        check("step_done_expected", int'(got_steps <= exp_steps), 1);
      end
    end
    pv = syn_vld; pr = syn_rdy; ps = syn_start; pe = syn_end; psd = step_done;
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic wait_quiet();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(exp_q.size() == 0 && got_steps == exp_steps && axon_rdy) && k < 3000);
    check("quiet_timeout", int'(k < 3000), 1);
  endtask
  task automatic cfg_write(input int n, input int dly, input int st, input int cnt);
    wait_quiet();
    tick();
    cfg_addr = AW'(n);
    cfg_data = {DW'(dly), 12'(st), 8'(cnt)};
    cfg_we = 1;
    tick();
    cfg_we = 0;
    m_dly[n] = dly; m_start[n] = st; m_cnt[n] = cnt;
  endtask
  task automatic fire(input int n, input bit upd);
    bit hs = 0;
    int k = 0;
    tick();
    axon_addr = AW'(n);
    axon_vld = 1;
    while (!hs && k < 3000) begin
      @(negedge clk);
      hs = axon_rdy;
      k++;
      tick();
    end
    axon_vld = 0;
    check("fire_handshake", hs, 1);
    if (hs && upd) model_fire(n);
  endtask
  task automatic step(input bit upd, input bit wt);
    tick();
    next_step = 1;
    tick();
    next_step = 0;
    if (upd) model_step();
    if (wt) wait_quiet();
  endtask
  task automatic do_clear(input bit act, input bit conf);
    int k = 0;
    tick();
    clear_act = act;
    clear_config = conf;
    @(negedge clk); #1;
    exp_q.delete();
    exp_steps = got_steps;
    s_m = 0;
    if (act) foreach (due[i, j]) due[i][j] = 1'b0;
    if (conf) for (int i = 0; i < N; i++) begin
      m_dly[i] = 0; m_start[i] = 0; m_cnt[i] = 0;
    end
    while (!clear_done && k < 4 * N) begin
      @(negedge clk);
      k++;
    end
    check("clear_done_lat_lo", int'(k >= N), 1);
    check("clear_done_lat_hi", int'(k <= N + 1), 1);
    if (conf) begin
      tick();
      cfg_addr = AW'(2);
      cfg_data = {4'd0, 12'h777, 8'd5};
      cfg_we = 1;
      tick();
      cfg_we = 0;
    end
    @(negedge clk);
    check("clear_done_held", clear_done, 1);
    tick();
    clear_act = 0;
    clear_config = 0;
    @(negedge clk);
    @(negedge clk);
    check("clear_done_fall", clear_done, 0);
    wait_quiet();
  endtask
  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_syn_vld", syn_vld, 0);
    check("rst_axon_rdy", axon_rdy, 0);
    check("rst_step_done", step_done, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_syn_start", syn_start, 0);
    check("rst_syn_end", syn_end, 0);
    tick();
    reset = 1;
    @(negedge clk);
    check("rdy_release_same", axon_rdy, 0);
    @(negedge clk);
    check("rdy_release_next", axon_rdy, 1);
    do_clear(1, 1);
    h0 = hs_cnt;
    fire(2, 1);
    wait_quiet();
    check("cfg_we_ignored", hs_cnt - h0, 0);
    cfg_write(5, 0, 'h100, 4);
    rdy_mode = 1;
    fire(5, 1);
    @(negedge clk);
    check("lat_t1_vld", syn_vld, 0);
    @(negedge clk);
    check("lat_t2_vld", syn_vld, 1);
    check("e5_start", syn_start, 'h100);
    check("e5_end", syn_end, 'h103);
    repeat (2) begin
      @(negedge clk);
      check("e5_hold_vld", syn_vld, 1);
      check("e5_hold_end", syn_end, 'h103);
    end
    rdy_mode = 0;
    wait_quiet();
    cfg_write(7, 3, 'h010, 1);
    fire(7, 1);
    wait_quiet();
    h0 = hs_cnt;
    g0 = got_steps;
    for (int i = 1; i <= 3; i++) begin
      step(1, 1);
      check("e7_steps", got_steps - g0, i);
      check("e7_emits", hs_cnt - h0, int'(i == 3));
    end
    check("e7_start", last_start, 'h010);
    check("e7_end", last_end, 'h010);
    cfg_write(9, 2, 'h200, 2);
    fire(9, 1);
    fire(9, 1);
    wait_quiet();
    h0 = hs_cnt;
    step(1, 1);
    step(1, 1);
    check("e9_coalesced", hs_cnt - h0, 1);
    check("e9_end", last_end, 'h201);
    cfg_write(3, 0, 'hFFE, 4);
    fire(3, 1);
    wait_quiet();
    check("e3_start", last_start, 'hFFE);
    check("e3_end_wrap", last_end, 'h001);
    cfg_write(4, 0, 'h050, 0);
    fire(4, 1);
    @(negedge clk);
    check("cnt0_rdy_t1", axon_rdy, 0);
    check("cnt0_vld_t1", syn_vld, 0);
    @(negedge clk);
    check("cnt0_rdy_t2", axon_rdy, 0);
    check("cnt0_vld_t2", syn_vld, 0);
    @(negedge clk);
    check("cnt0_rdy_t3", axon_rdy, 1);
    cfg_write(11, 1, 'h300, 3);
    fire(11, 1);
    fire(9, 1);
    fire(7, 1);
    wait_quiet();
    g0 = got_steps;
    step(1, 0);
    repeat (3) tick();
    step(1, 0);
    step(0, 0);
    wait_quiet();
    check("double_step_count", got_steps - g0, 2);
    fire(11, 1);
    fire(7, 1);
    fire(9, 1);
    wait_quiet();
    step(1, 0);
    repeat (3) tick();
    do_clear(1, 0);
    h0 = hs_cnt;
    for (int i = 0; i < D; i++) step(1, 1);
    check("clear_act_flushed", hs_cnt - h0, 0);
    fire(9, 1);
    fire(5, 0);
    reset = 0;
    tick();
    reset = 1;
    @(negedge clk);
    check("rst_mid_rdy", axon_rdy, 0);
    check("rst_mid_vld", syn_vld, 0);
    @(negedge clk);
    check("rst_mid_rdy_rise", axon_rdy, 1);
    s_m = 0;
    h0 = hs_cnt;
    for (int i = 0; i < D; i++) step(1, 1);
    check("ram_kept_over_reset", hs_cnt - h0, 1);
    for (int n = 0; n < N; n++)
      cfg_write(n, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, D - 1), $urandom_range(0, 4095), $urandom_range(0, 6));
    for (int it = 0; it < 250; it++) begin
      int r = $urandom_range(0, 9);
      if (r < 5) fire($urandom_range(0, N - 1), 1);
      else if (r < 8) step(1, 1);
      else if (r == 8) cfg_write($urandom_range(0, N - 1), $urandom_range(0, D - 1), $urandom_range(0, 4095), $urandom_range(0, 6));
      else begin
        wait_quiet();
        step(1, 0);
        repeat (2) tick();
        step(1, 1);
      end
    end
    wait_quiet();
    check("queue_drained", exp_q.size(), 0);
    check("steps_total", got_steps, exp_steps);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ucaspian_axon_dq.md
UCASPIAN_AXON_DQ -- requirements
Module: ucaspian_axon_dq

Interface
REQ-001 SHALL have parameter NEURONS, default 256, number of axon entries (power of 2, >=16).
REQ-002 SHALL have parameter SYN_W, default 12, synapse address width.
REQ-003 SHALL have parameter CNT_W, default 8, synapse-count field width.
REQ-004 SHALL have parameter DELAY_W, default 4; D = 2^DELAY_W delay slots, legal delay 0..D-1.
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk  input  1  clock; reset  input  1  synchronous active-low reset (0 = reset).
REQ-006 SHALL have ports: enable  input  1  advance FSM; clear_act  input  1  clear pending fires; clear_config  input  1  clear config RAM; clear_done  output  1  clear complete.
REQ-007 SHALL have ports: cfg_addr  input  log2(NEURONS)  entry index; cfg_data  input  DELAY_W+SYN_W+CNT_W  {delay, syn_start, syn_cnt}; cfg_we  input  1  write strobe.
REQ-008 SHALL have ports: next_step  input  1  timestep boundary; step_done  output  1  one-cycle pulse, step scan complete.
REQ-009 SHALL have ports: axon_addr  input  log2(NEURONS)  firing neuron; axon_vld  input  1; axon_rdy  output  1.
REQ-010 SHALL have ports: syn_start  output  SYN_W; syn_end  output  SYN_W; syn_vld  output  1; syn_rdy  input  1.

Function
REQ-011 Storage: config RAM NEURONS x (DELAY_W+SYN_W+CNT_W); delay RAM NEURONS x D bits; slot pointer ptr (DELAY_W bits).
REQ-012 cfg_we writes cfg_data to config RAM at cfg_addr in one cycle; ignored while clear_config high.
REQ-013 FSM states: IDLE, READ, EMIT, SCAN, SCAN_EMIT, CLEAR; transitions only when enable high, except CLEAR and reset.
REQ-014 IDLE: axon_rdy=1; on axon_vld&&axon_rdy capture axon_addr, drop axon_rdy, go READ.
REQ-015 READ: fetch config entry; delay field 0 -> EMIT; delay d>0 -> set bit (ptr+d) mod D of delay RAM[addr] (OR, coalescing duplicates), return IDLE.
REQ-016 Zero-delay latency: handshake cycle T, syn_vld high at T+2 with that entry's outputs.
REQ-017 EMIT/SCAN_EMIT: syn_start=start; syn_end=start+cnt-1 truncated to SYN_W (wraps); hold syn_vld and outputs stable until syn_vld&&syn_rdy, then drop syn_vld next cycle.
REQ-018 cnt==0: no syn_vld; EMIT returns to IDLE, SCAN_EMIT resumes SCAN, next cycle.
REQ-019 next_step in IDLE: ptr <= ptr+1 mod D, enter SCAN at index 0.
REQ-020 SCAN: per index, if delay RAM[idx] bit ptr set, clear that bit, go SCAN_EMIT, then resume at idx+1; else advance idx one per cycle.
REQ-021 After index NEURONS-1 processed: step_done high exactly one cycle, return IDLE.
REQ-022 next_step outside IDLE SHALL be latched (one-deep pending flag) and serviced on next IDLE entry ahead of axon_vld; a second while pending is dropped.
REQ-023 axon_rdy SHALL be 0 in all states except IDLE.
REQ-024 A fire with delay d issued in step s SHALL emit during scan of step s+d (ptr wrap mod D).
REQ-025 clear_act or clear_config high SHALL abort any operation, drop syn_vld/axon_rdy, enter CLEAR.
REQ-026 CLEAR: zero delay RAM (clear_act) and/or config RAM (clear_config), one entry per cycle, NEURONS cycles; reset ptr to 0.
REQ-027 clear_done high from cycle after last entry cleared while request held; low when requests low.

Reset
REQ-028 reset=0 at a clk edge: FSM IDLE, ptr=0, pending step 0, syn_vld=0, axon_rdy=0, step_done=0, clear_done=0, syn_start=0, syn_end=0.
REQ-029 Reset SHALL NOT clear RAM contents; clear_act/clear_config are required for that.
REQ-030 Reset mid-handshake SHALL discard the in-flight fire; axon_rdy rises the cycle after reset releases.

Verification
REQ-031 Entry 5 = {0,0x100,4}; fire 5 -> syn_vld at T+2 with start 0x100, end 0x103; syn_rdy held low 3 cycles -> outputs stable.
REQ-032 Entry 7 = {3,0x010,1}; fire 7, then next_step x3 -> emit start=end=0x010 only in third scan; step_done each scan.
REQ-033 Entry 9 delay 2, fire 9 twice same step -> single emission two steps later (coalesced).
REQ-034 Entry 3 = {0,0xFFE,4} -> syn_end=0x001 (wrap); entry cnt=0 -> no syn_vld, axon_rdy back in 2 cycles.
REQ-035 next_step during scan -> second scan follows immediately, two step_done pulses; clear_act mid-scan -> no further emissions, clear_done after NEURONS cycles, all pending fires gone.
